// File: rtl/wb_icape6_pkg.sv
// Shared definitions for the Wishbone-to-ICAP_SPARTAN6 bridge:
// FSM state codes, ICAP command words and the packet-header helper.
package wb_icape6_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WSEQ   = 3'd1;
    localparam logic [2:0] ST_RHDR   = 3'd2;
    localparam logic [2:0] ST_RTURN1 = 3'd3;
    localparam logic [2:0] ST_RREAD  = 3'd4;
    localparam logic [2:0] ST_RTURN2 = 3'd5;
    localparam logic [2:0] ST_DESYNC = 3'd6;
    localparam logic [2:0] ST_ACK    = 3'd7;

    localparam logic [15:0] DUMMY       = 16'hFFFF;
    localparam logic [15:0] SYNC1       = 16'hAA99;
    localparam logic [15:0] SYNC2       = 16'h5566;
    localparam logic [15:0] NOOP        = 16'h2000;
    localparam logic [15:0] WR_HDR_BASE = 16'h3001;
    localparam logic [15:0] RD_HDR_BASE = 16'h2801;
    localparam logic [15:0] CMD_HDR     = 16'h30A1;
    localparam logic [15:0] DESYNC_CMD  = 16'h000D;

    // Type-1 packet header: register address lives in bits [10:5].
    function automatic logic [15:0] hdr_word(input logic [15:0] base, input logic [4:0] addr);
        return base | {6'b0, addr, 5'b0};
    endfunction

endpackage

// File: rtl/icape_seq_rom.sv
// Word table for the ICAP sequences: maps (state, step) to the word to
// present and flags the final step of each emitting state.
module icape_seq_rom
    import wb_icape6_pkg::*;
(
    input  logic [2:0]  state,
    input  logic [3:0]  step,
    input  logic [4:0]  addr,
    input  logic [15:0] data,
    output logic [15:0] word,
    output logic        last
);

    always_comb begin
        word = 16'h0000;
        last = 1'b0;
        case (state)
            ST_WSEQ: begin
                case (step)
                    4'd0: word = DUMMY;
                    4'd1: word = SYNC1;
                    4'd2: word = SYNC2;
                    4'd3: word = NOOP;
                    4'd4: word = hdr_word(WR_HDR_BASE, addr);
                    4'd5: word = data;
                    4'd6: word = NOOP;
                    default: begin
                        word = NOOP;
                        last = 1'b1;
                    end
                endcase
            end
            ST_RHDR: begin
                case (step)
                    4'd0: word = DUMMY;
                    4'd1: word = SYNC1;
                    4'd2: word = SYNC2;
                    4'd3: word = NOOP;
                    4'd4: word = hdr_word(RD_HDR_BASE, addr);
                    4'd5: word = NOOP;
                    default: begin
                        word = NOOP;
                        last = 1'b1;
                    end
                endcase
            end
            ST_DESYNC: begin
                case (step)
                    4'd0: word = CMD_HDR;
                    4'd1: word = DESYNC_CMD;
                    4'd2: word = NOOP;
                    default: begin
                        word = NOOP;
                        last = 1'b1;
                    end
                endcase
            end
            default: begin
                word = 16'h0000;
                last = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wb_icape6.sv
// Wishbone pipelined slave giving single-register read/write access to the
// Spartan-6 configuration logic through ICAP_SPARTAN6.
//
// state   | meaning
// IDLE    | waiting for a request; only state with stall low
// WSEQ    | dummy, sync, noop, write header, data, two noops
// RHDR    | dummy, sync, noop, read header, two noops
// RTURN1  | bus turnaround before reading (CE/WRITE released)
// RREAD   | CE low, WRITE high; capture O bus on first non-busy edge
// RTURN2  | bus turnaround after reading
// DESYNC  | CMD header, DESYNC, two noops
// ACK     | one cycle; registers the ack if the cycle was kept alive
module wb_icape6
    import wb_icape6_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        o_icap_cen,
    output logic        o_icap_wrn,
    output logic [15:0] o_icap_data,
    input  logic [15:0] i_icap_data,
    input  logic        i_icap_busy
);

    state_t      state;
    logic [3:0]  step;
    logic [4:0]  addr_q;
    logic [15:0] data_q;
    logic        cyc_ok;
    logic [15:0] rom_word;
    logic        rom_last;
    logic        emitting;
    logic        unused_hi;

    assign unused_hi = ^i_wb_data[31:16];

    icape_seq_rom u_rom (
        .state (state),
        .step  (step),
        .addr  (addr_q),
        .data  (data_q),
        .word  (rom_word),
        .last  (rom_last)
    );

    assign emitting   = (state == ST_WSEQ) || (state == ST_RHDR) || (state == ST_DESYNC);
    assign o_wb_stall = (state != ST_IDLE);

    always_comb begin
        o_icap_cen  = 1'b1;
        o_icap_wrn  = 1'b1;
        o_icap_data = 16'h0000;
        if (emitting) begin
            o_icap_cen  = 1'b0;
            o_icap_wrn  = 1'b0;
            o_icap_data = rom_word;
        end else if (state == ST_RREAD) begin
            o_icap_cen = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            step      <= 4'd0;
            addr_q    <= 5'd0;
            data_q    <= 16'h0000;
            cyc_ok    <= 1'b0;
            o_wb_ack  <= 1'b0;
            o_wb_data <= 32'h0000_0000;
        end else begin
            o_wb_ack <= (state == ST_ACK) && cyc_ok && i_wb_cyc;

            // Once the master abandons the cycle, the ack stays suppressed
            // but the sequence still finishes so the config logic desyncs.
            if ((state != ST_IDLE) && !i_wb_cyc)
                cyc_ok <= 1'b0;

            case (state)
                ST_IDLE: begin
                    step <= 4'd0;
                    if (i_wb_stb) begin
                        addr_q <= i_wb_addr;
                        data_q <= i_wb_data[15:0];
                        cyc_ok <= i_wb_cyc;
                        state  <= i_wb_we ? ST_WSEQ : ST_RHDR;
                    end
                end
                ST_WSEQ, ST_RHDR, ST_DESYNC: begin
                    if (!i_icap_busy) begin
                        if (rom_last) begin
                            step <= 4'd0;
                            case (state)
                                ST_WSEQ: state <= ST_DESYNC;
                                ST_RHDR: state <= ST_RTURN1;
                                default: state <= ST_ACK;
                            endcase
                        end else begin
                            step <= step + 4'd1;
                        end
                    end
                end
                ST_RTURN1: begin
                    step  <= 4'd0;
                    state <= ST_RREAD;
                end
                ST_RREAD: begin
                    step <= 4'd0;
                    if (!i_icap_busy) begin
                        o_wb_data <= {16'h0000, i_icap_data};
                        state     <= ST_RTURN2;
                    end
                end
                ST_RTURN2: begin
                    step  <= 4'd0;
                    state <= ST_DESYNC;
                end
                default: begin
                    step  <= 4'd0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_icape6.sv
// Directed bench for wb_icape6: expected ICAP words are queued per request
// and checked as each word is consumed; latency and ack timing are checked per request.
module tb_wb_icape6;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [4:0]  i_wb_addr = 5'd0;
    logic [31:0] i_wb_data = 32'h0;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;
    logic        o_icap_cen;
    logic        o_icap_wrn;
    logic [15:0] o_icap_data;
    logic [15:0] i_icap_data = 16'h0;
    logic        i_icap_busy = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    int n_ack_total = 0;
    int hold_3081 = 0;
    logic [15:0] sb[$];

    wb_icape6 dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wb_cyc    (i_wb_cyc),
        .i_wb_stb    (i_wb_stb),
        .i_wb_we     (i_wb_we),
        .i_wb_addr   (i_wb_addr),
        .i_wb_data   (i_wb_data),
        .o_wb_ack    (o_wb_ack),
        .o_wb_stall  (o_wb_stall),
        .o_wb_data   (o_wb_data),
        .o_icap_cen  (o_icap_cen),
        .o_icap_wrn  (o_icap_wrn),
        .o_icap_data (o_icap_data),
        .i_icap_data (i_icap_data),
        .i_icap_busy (i_icap_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every consumed ICAP word is popped and compared.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_wb_ack) n_ack_total++;
            if (!o_icap_cen && o_icap_data == 16'h3081) hold_3081++;
            if (!o_icap_cen && !o_icap_wrn && !i_icap_busy) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $error("FAIL icap_extra: observed %h expected no word", o_icap_data);
                end else begin
                    logic [15:0] exp_w;
                    exp_w = sb.pop_front();
                    n_cmp++;
                    assert (o_icap_data === exp_w) else begin
                        n_fail++;
                        $error("FAIL icap_word: observed %h expected %h", o_icap_data, exp_w);
                    end
                end
            end
        end
    end

    task automatic push_words(input logic we, input logic [4:0] a, input logic [15:0] d);
        logic [15:0] ash;
        ash = 16'(a) << 5;
        sb.push_back(16'hFFFF);
        sb.push_back(16'hAA99);
        sb.push_back(16'h5566);
        sb.push_back(16'h2000);
        if (we) begin
            sb.push_back(16'h3001 | ash);
            sb.push_back(d);
            sb.push_back(16'h2000);
            sb.push_back(16'h2000);
        end else begin
            sb.push_back(16'h2801 | ash);
            sb.push_back(16'h2000);
            sb.push_back(16'h2000);
        end
        sb.push_back(16'h30A1);
        sb.push_back(16'h000D);
        sb.push_back(16'h2000);
        sb.push_back(16'h2000);
    endtask

    // Called at a negedge with the DUT idle. exp_ack = 0 means no ack expected.
    task automatic run_req(input string tag, input logic we, input logic [4:0] a,
                           input logic [15:0] d, input logic [15:0] rd,
                           input int exp_end, input int exp_ack, input int drop_at,
                           input int rst_at, input bit busy_hdr, input bit keep_stb);
        int ack_k = 0;
        int stall_k = 0;
        int end_k = 0;
        int busy_cnt = 0;
        bit busy_used = 0;
        push_words(we, a, d);
        i_wb_cyc    = 1'b1;
        i_wb_stb    = 1'b1;
        i_wb_we     = we;
        i_wb_addr   = a;
        i_wb_data   = {16'hDEAD, d};
        i_icap_data = rd;
        @(posedge i_clk);
        #2;
        if (!keep_stb) i_wb_stb = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) i_icap_busy = 1'b0;
            end else if (busy_hdr && !busy_used && !o_icap_cen && o_icap_data == 16'h3081) begin
                i_icap_busy = 1'b1;
                busy_cnt = 3;
                busy_used = 1;
            end
            if (k == drop_at) i_wb_cyc = 1'b0;
            if (k == rst_at) begin
                i_rst = 1'b1;
                #1;
                chk({tag, "_rst_ack"}, {31'b0, o_wb_ack}, 32'd0);
                chk({tag, "_rst_stall"}, {31'b0, o_wb_stall}, 32'd0);
                chk({tag, "_rst_cen_wrn"}, {30'b0, o_icap_cen, o_icap_wrn}, 32'd3);
                chk({tag, "_rst_icap"}, {16'b0, o_icap_data}, 32'd0);
                chk({tag, "_rst_wbdata"}, o_wb_data, 32'd0);
                @(negedge i_clk);
                i_rst = 1'b0;
                sb.delete();
                end_k = k;
                break;
            end
            @(negedge i_clk);
            if (o_wb_ack && ack_k == 0) ack_k = k;
            if (o_wb_stall) stall_k++;
            if (exp_ack == 16 && (k == 8 || k == 10))
                chk($sformatf("%s_turn%0d", tag, k), {30'b0, o_icap_cen, o_icap_wrn}, 32'd3);
            if (exp_ack == 16 && k == 9)
                chk({tag, "_rread"}, {30'b0, o_icap_cen, o_icap_wrn}, 32'd1);
            if (!o_wb_stall) begin
                end_k = k;
                break;
            end
            @(posedge i_clk);
            #2;
        end
        if (!keep_stb) i_wb_cyc = 1'b0;
        if (rst_at == 0) begin
            chk({tag, "_end"}, end_k, exp_end);
            chk({tag, "_ack_cycle"}, ack_k, exp_ack);
            chk({tag, "_stall_cycles"}, stall_k, exp_end - 1);
            chk({tag, "_sb_left"}, sb.size(), 0);
            if (!we && exp_ack != 0)
                chk({tag, "_rdata"}, o_wb_data, {16'h0000, rd});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst = 1'b1;
        #1;
        chk("reset_ack", {31'b0, o_wb_ack}, 32'd0);
        chk("reset_stall", {31'b0, o_wb_stall}, 32'd0);
        chk("reset_cen_wrn", {30'b0, o_icap_cen, o_icap_wrn}, 32'd3);
        chk("reset_icap", {16'b0, o_icap_data}, 32'd0);
        chk("reset_wbdata", o_wb_data, 32'd0);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        run_req("wr04", 1'b1, 5'h04, 16'h1234, 16'h0000, 14, 14, 0, 0, 0, 0);
        run_req("rd0c", 1'b0, 5'h0C, 16'h0000, 16'hBEEF, 16, 16, 0, 0, 0, 0);

        hold_3081 = 0;
        run_req("wrbusy", 1'b1, 5'h04, 16'h5A5A, 16'h0000, 17, 17, 0, 0, 1, 0);
        chk("busy_hold_3081", hold_3081, 4);

        run_req("wrdrop", 1'b1, 5'h1F, 16'hFFFF, 16'h0000, 14, 0, 4, 0, 0, 0);
        run_req("wrafter", 1'b1, 5'h01, 16'h0001, 16'h0000, 14, 14, 0, 0, 0, 0);

        run_req("rdrst", 1'b0, 5'h0C, 16'h0000, 16'h1357, 0, 0, 0, 9, 0, 0);
        run_req("rd03", 1'b0, 5'h03, 16'h0000, 16'hCAFE, 16, 16, 0, 0, 0, 0);

        run_req("wrhold1", 1'b1, 5'h02, 16'h00A5, 16'h0000, 14, 14, 0, 0, 0, 1);
        run_req("wrhold2", 1'b1, 5'h02, 16'h00A5, 16'h0000, 14, 14, 0, 0, 0, 0);
        chk("wbdata_held", o_wb_data, 32'h0000_CAFE);

        repeat (3) @(negedge i_clk);
        chk("ack_total", n_ack_total, 7);
        chk("idle_stall", {31'b0, o_wb_stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
